// File: rtl/inst_mem_loader.sv
// inst_mem_loader: instruction store with a byte-serial download port.
// Bytes pack little-endian into words written from word 0 upward.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   addr, rden        : fetch word address and read enable
//   inst, inst_vld    : registered instruction and its valid flag
//   dl_start, dl_end  : download begin / image complete pulses
//   dl_byte, dl_valid : download byte stream
//   dl_ready          : byte accepted this cycle when dl_valid is high
//   busy, dl_done     : download in progress / completion pulse
//   dl_ovf, dl_words  : sticky overflow flag / words written (saturating)
module inst_mem_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] NOP    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rden,
  output logic [31:0]       inst,
  output logic              inst_vld,
  input  logic              dl_start,
  input  logic [7:0]        dl_byte,
  input  logic              dl_valid,
  output logic              dl_ready,
  input  logic              dl_end,
  output logic              busy,
  output logic              dl_done,
  output logic              dl_ovf,
  output logic [ADDR_W:0]   dl_words
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mem [DEPTH];
  logic [1:0]  bcnt;
  logic [1:0]  bcnt_acc;
  logic [23:0] wbuf;
  logic        full;
  logic        acc;
  logic        take;
  logic        ovf_acc;
  logic        we;
  logic        done_nxt;
  logic [31:0] wdata;

  // dl_words doubles as the write pointer; its MSB marks a full memory,
  // so the pointer never wraps back onto word 0.
  assign full     = dl_words[ADDR_W];
  assign dl_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign acc      = dl_valid & dl_ready;
  assign take     = acc & ~full;

  // Byte count and overflow as they stand once this cycle's byte is in,
  // so a byte arriving with dl_end is counted before end handling.
  assign bcnt_acc = take ? bcnt + 2'd1 : bcnt;
  assign ovf_acc  = dl_ovf | (acc & full);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    wdata     = {dl_byte, wbuf};
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dl_start) state_nxt = LOAD;
      end
      LOAD: begin
        we = take & (bcnt == 2'd3);
        if (dl_end) begin
          if (bcnt_acc != 2'd0 && !ovf_acc) begin
            state_nxt = FLUSH;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      FLUSH: begin
        // wbuf lanes not yet filled are already zero
        we        = 1'b1;
        wdata     = {8'h00, wbuf};
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst     <= NOP;
      inst_vld <= 1'b0;
      dl_done  <= 1'b0;
      dl_ovf   <= 1'b0;
      dl_words <= '0;
      bcnt     <= 2'd0;
      wbuf     <= '0;
    end else begin
      dl_done <= done_nxt;

      if (state == IDLE && dl_start) begin
        bcnt     <= 2'd0;
        wbuf     <= '0;
        dl_words <= '0;
        dl_ovf   <= 1'b0;
      end

      if (acc && full) dl_ovf <= 1'b1;

      if (take) begin
        bcnt <= bcnt + 2'd1;
        unique case (bcnt)
          2'd0: wbuf[7:0]   <= dl_byte;
          2'd1: wbuf[15:8]  <= dl_byte;
          2'd2: wbuf[23:16] <= dl_byte;
          2'd3: wbuf        <= '0;
          default: wbuf     <= '0;
        endcase
      end

      if (we) dl_words <= dl_words + ONE;

      if (state == FLUSH) begin
        bcnt <= 2'd0;
        wbuf <= '0;
      end

      if (rden) begin
        if (state == IDLE) begin
          inst     <= mem[addr];
          inst_vld <= 1'b1;
        end else begin
          inst     <= NOP;
          inst_vld <= 1'b0;
        end
      end else begin
        inst_vld <= 1'b0;
      end
    end
  end

  // Memory is never reset; an abort keeps words already written.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[dl_words[ADDR_W-1:0]] <= wdata;
  end

endmodule
